// File: rtl/pipelined_add_sub_pkg.sv
// rtl/pipelined_add_sub_pkg.sv - shared types and helpers for the pipelined adder/subtractor
package add_sub_pkg;

  typedef enum logic [1:0] {
    SAT_WRAP     = 2'b00,
    SAT_UNSIGNED = 2'b01,
    SAT_SIGNED   = 2'b10,
    SAT_RESERVED = 2'b11
  } sat_mode_e;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// rtl/pipelined_add_sub_if.sv - operand/result stream bundle for pipelined_add_sub
interface pipelined_add_sub_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             subtract;
  logic [1:0]       sat_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, subtract, sat_mode, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, subtract, sat_mode, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, negative
  );

endinterface

// File: rtl/pipelined_add_sub_slice.sv
// rtl/pipelined_add_sub_slice.sv - CHUNK-bit combinational add with carry in and carry out
module add_sub_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - chunked carry-pipeline adder/subtractor with stall handshake
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_add_sub_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_param_check
    $error("pipelined_add_sub: WIDTH must be a multiple of CHUNK and at least 2");
  end

  // Operands shift down by CHUNK per stage so every slice reads the low bits.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum;
    logic             sub;
    sat_mode_e        mode;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

  stage_t stg_in  [STAGES];
  stage_t stg_out [STAGES];

  logic             adv;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  flags_t           flags_d, flags_q;

  assign adv          = bus.out_ready || !out_valid_q;
  assign bus.in_ready = adv;

  assign stg_in[0] = '{
    valid: bus.in_valid,
    carry: bus.subtract,
    a_rem: bus.a,
    b_rem: bus.subtract ? ~bus.b : bus.b,
    sum:   '0,
    sub:   bus.subtract,
    mode:  sat_mode_e'(bus.sat_mode),
    a_msb: bus.a[WIDTH-1],
    b_msb: bus.b[WIDTH-1]
  };

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    stage_t           nxt;

    add_sub_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (stg_in[s].a_rem[CHUNK-1:0]),
      .b    (stg_in[s].b_rem[CHUNK-1:0]),
      .cin  (stg_in[s].carry),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    always_comb begin
      nxt = stg_in[s];
      nxt.carry = slice_cout;
      nxt.a_rem = stg_in[s].a_rem >> CHUNK;
      nxt.b_rem = stg_in[s].b_rem >> CHUNK;
      nxt.sum[s*CHUNK +: CHUNK] = slice_sum;
    end

    assign stg_out[s] = nxt;

    if (s < STAGES - 1) begin : g_reg
      stage_t pipe_d, pipe_q;

      always_comb begin
        pipe_d = pipe_q;
        if (adv) pipe_d = nxt;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe_q <= '0;
        else     pipe_q <= pipe_d;
      end

      assign stg_in[s+1] = pipe_q;
    end
  end

  stage_t           last;
  logic             raw_msb;
  logic             ovf;
  logic [WIDTH-1:0] sat;

  assign last    = stg_out[STAGES-1];
  assign raw_msb = last.sum[WIDTH-1];

  always_comb begin
    if (last.sub) ovf = (last.a_msb != last.b_msb) && (raw_msb != last.a_msb);
    else          ovf = (last.a_msb == last.b_msb) && (raw_msb != last.a_msb);

    sat = last.sum;
    case (last.mode)
      SAT_UNSIGNED: begin
        if (!last.sub && last.carry)     sat = '1;
        else if (last.sub && !last.carry) sat = '0;
      end
      SAT_SIGNED: begin
        if (ovf) sat = last.a_msb ? SMIN : SMAX;
      end
      default: sat = last.sum;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (adv) begin
      out_valid_d = last.valid;
      result_d    = sat;
      flags_d     = '{cout: last.carry, overflow: ovf, zero: (sat == '0), negative: sat[WIDTH-1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = flags_q.cout;
  assign bus.overflow  = flags_q.overflow;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;

endmodule
